// File: rtl/fifo_sync_1clk.sv
// Purpose : single-clock first-word-fall-through FIFO, DSIZE-bit words, 2**ASIZE entries.
// Latency : a word written on edge N is visible on rdata (and clears rempty) after edge N.
// Backpress: wfull rejects further writes, rempty rejects reads; rejected requests are silently dropped.
//
// Ports:
//   wclk    - sole clock, all state changes on its rising edge
//   wrst_n  - asynchronous assert, synchronous release, active-low reset
//   winc    - push request, accepted when wfull=0; wdata sampled with it
//   wfull   - registered, buffer holds 2**ASIZE words
//   rinc    - pop request, accepted when rempty=0
//   rdata   - head-of-queue word, forced to zero while empty
//   rempty  - registered, buffer holds no words
//   level   - (only with FIFO_LEVEL_EN) registered occupancy, 0..2**ASIZE
//
// Build option: define FIFO_LEVEL_EN to add the registered occupancy output.
module fifo_sync_1clk #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty
`ifdef FIFO_LEVEL_EN
  ,
  output logic [ASIZE:0]   level
`endif
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] PTR_ONE = {{ASIZE{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the address bits match.
  logic [ASIZE:0]   wptr_q, wptr_d;
  logic [ASIZE:0]   rptr_q, rptr_d;
  logic             wfull_q, wfull_d;
  logic             rempty_q, rempty_d;
  logic [DSIZE-1:0] mem_q [DEPTH];

  logic             wr_en;
  logic             rd_en;
  logic             mem_we;
  logic [ASIZE-1:0] waddr;
  logic [ASIZE-1:0] raddr;

  // Requests only take effect against the registered flags, so a push while
  // empty and a pop while full both work in the same cycle.
  assign wr_en = winc & ~wfull_q;
  assign rd_en = rinc & ~rempty_q;
  assign waddr = wptr_q[ASIZE-1:0];
  assign raddr = rptr_q[ASIZE-1:0];

  // Array is never reset; a write presented while reset is held must not
  // disturb its contents either.
  assign mem_we = wr_en & wrst_n;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (rd_en) begin
      rptr_d = rptr_q + PTR_ONE;
    end
  end

  // Flags come from the next-state pointers so they line up with the
  // pointer update instead of trailing it by a cycle.
  always_comb begin
    rempty_d = (wptr_d == rptr_d);
    wfull_d  = (wptr_d[ASIZE] != rptr_d[ASIZE]) &&
               (wptr_d[ASIZE-1:0] == rptr_d[ASIZE-1:0]);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
    end
  end

  always_ff @(posedge wclk) begin
    if (mem_we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Fall-through head view; zeroed while empty so stale array contents
  // never leak out after a drain or reset.
  assign rdata  = rempty_q ? '0 : mem_q[raddr];
  assign wfull  = wfull_q;
  assign rempty = rempty_q;

`ifdef FIFO_LEVEL_EN
  logic [ASIZE:0] level_q;
  logic [ASIZE:0] level_d;

  // Modulo subtraction of the wrap-extended pointers gives 0..DEPTH directly.
  assign level_d = wptr_d - rptr_d;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level = level_q;
`endif

endmodule

// File: tb/tb_fifo_sync_1clk.sv
module tb_fifo_sync_1clk;

  localparam int DEPTH = 16;

  logic       wclk;
  logic       wrst_n;
  logic       winc;
  logic [7:0] wdata;
  logic       wfull;
  logic       rinc;
  logic [7:0] rdata;
  logic       rempty;
`ifdef FIFO_LEVEL_EN
  logic [4:0] level;
`endif

  fifo_sync_1clk #(.DSIZE(8), .ASIZE(4)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .winc   (winc),
    .wdata  (wdata),
    .wfull  (wfull),
    .rinc   (rinc),
    .rdata  (rdata),
    .rempty (rempty)
`ifdef FIFO_LEVEL_EN
    ,
    .level  (level)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int tests = 0;
  int fails = 0;

  // Reference model: queue of words the FIFO should hold, plus occupancy.
  logic [7:0] exp_q[$];
  int         occ = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_rempty"}, {31'd0, rempty}, {31'd0, occ == 0});
    chk({tag, "_wfull"},  {31'd0, wfull},  {31'd0, occ == DEPTH});
`ifdef FIFO_LEVEL_EN
    chk({tag, "_level"}, {27'd0, level}, occ);
`endif
  endtask

  // Issue one clock of requests; the model decides acceptance from its own
  // occupancy and queues accepted write data as the expected output.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d,
                       output bit aw, output bit ar);
    winc  = w;
    rinc  = r;
    wdata = d;
    aw = w && (occ < DEPTH);
    ar = r && (occ > 0);
    if (aw) exp_q.push_back(d);
    occ = occ + int'(aw) - int'(ar);
    @(posedge wclk);
    #1;
    chk_flags("cyc");
  endtask

  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    bit aw, ar;
    cycle(w, r, d, aw, ar);
  endtask

  task automatic do_reset(input string tag);
    winc = 1'b0;
    rinc = 1'b0;
    #2;
    wrst_n = 1'b0;
    exp_q.delete();
    occ = 0;
    #1;
    chk({tag, "_rempty"}, {31'd0, rempty}, 32'd1);
    chk({tag, "_wfull"},  {31'd0, wfull},  32'd0);
    chk({tag, "_rdata"},  {24'd0, rdata},  32'd0);
`ifdef FIFO_LEVEL_EN
    chk({tag, "_level"},  {27'd0, level},  32'd0);
`endif
    @(negedge wclk);
    #2;
    wrst_n = 1'b1;
    @(posedge wclk);
    #1;
  endtask

  // Monitor: checks the head word against the model whenever the DUT presents
  // data and retires the expected entry when a pop is requested.
  always @(negedge wclk) begin
    if (wrst_n) begin
      if (rempty) begin
        chk("rdata_when_empty", {24'd0, rdata}, 32'd0);
      end else if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL head_unexpected actual=%0h required=none at %0t", rdata, $time);
      end else begin
        chk("head_data", {24'd0, rdata}, {24'd0, exp_q[0]});
        if (rinc) void'(exp_q.pop_front());
      end
    end
  end

  initial begin : stim
    int wr_done;
    int rd_done;
    int ncyc;
    bit aw, ar;
    bit w, r;

    wrst_n = 1'b1;
    winc   = 1'b0;
    rinc   = 1'b0;
    wdata  = 8'h00;

    // Reset asserted mid-clock, checked before any edge.
    do_reset("init_reset");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00);

    // Underflow then single write.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b0, 8'hA5);
    cyc(1'b0, 1'b0, 8'h00);
    chk("underflow_head", {24'd0, rdata}, 32'h0000_00A5);
    cyc(1'b0, 1'b1, 8'h00);

    // Fill, overflow attempt, drain, extra pop.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 8'(i));
    cyc(1'b1, 1'b0, 8'hFF);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);

    // Simultaneous push/pop at constant occupancy of 5.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 8'($urandom));
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h00);

    // Interleaved randomly throttled traffic across pointer wraps.
    wr_done = 0;
    rd_done = 0;
    ncyc    = 0;
    while ((wr_done < 40 || rd_done < 40) && ncyc < 2000) begin
      if (wr_done < 20) begin
        w = ($urandom_range(3) != 0);
        r = ($urandom_range(3) == 0);
      end else begin
        w = ($urandom_range(3) == 0);
        r = ($urandom_range(3) != 0);
      end
      w = w && (wr_done < 40);
      r = r && (rd_done < 40);
      cycle(w, r, 8'($urandom), aw, ar);
      wr_done += int'(aw);
      rd_done += int'(ar);
      ncyc++;
    end
    chk("interleave_writes", wr_done, 32'd40);
    chk("interleave_reads",  rd_done, 32'd40);

    // Reset with 7 words stored; next write must become the head.
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'($urandom));
    do_reset("midop_reset");
    chk_flags("after_reset");
    cyc(1'b1, 1'b0, 8'h3C);
    cyc(1'b0, 1'b0, 8'h00);
    chk("post_reset_head", {24'd0, rdata}, 32'h0000_003C);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);

    @(negedge wclk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
